processor_nbit: RTL

PROCESSOR_NBIT -- requirements
Module: processor_nbit

---
 rtl/processor_nbit.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/processor_nbit.sv
// processor_nbit: small multi-cycle accumulator-style processor.
//
// Each instruction runs FETCH (imem_en pulse), WAIT (until imem_ready),
// then a single EXEC cycle. IN parks in INWAIT until a fresh key press.
// HALT parks in HALT until reset.
//
// Parameters:
//   DATA_W  datapath / register width (4..16)
//   ADDR_W  program address width (2..8)
//   NREG    register count (power of 2, 2..16)
//
// Ports:
//   clk, reset_p          rising-edge clock, synchronous active-high reset
//   imem_addr / imem_en   fetch address (always pc) and fetch request
//   imem_rdata/imem_ready instruction word and its valid strobe
//   key_value / key_valid keypad code and key-present level
//   kout                  last key accepted by IN
//   outreg_data/out_valid last OUT value and its one-cycle strobe
//   halted                high while in HALT
module processor_nbit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int NREG   = 4
) (
    input  logic              clk,
    input  logic              reset_p,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_en,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ready,
    input  logic [3:0]        key_value,
    input  logic              key_valid,
    output logic [3:0]        kout,
    output logic [DATA_W-1:0] outreg_data,
    output logic              out_valid,
    output logic              halted
);
    localparam int RIDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_INWAIT = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_IN   = 4'h7;
    localparam logic [3:0] OP_OUT  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_JN   = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hC;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic              zero_flag_q, zero_flag_d;
    logic              sign_flag_q, sign_flag_d;
    logic              carry_flag_q, carry_flag_d;
    logic [DATA_W-1:0] outreg_q, outreg_d;
    logic              out_valid_q, out_valid_d;
    logic [3:0]        kout_q, kout_d;
    logic              key_prev_q;

    logic [DATA_W-1:0] rf_q [NREG];
    logic              rf_we;
    logic [RIDX_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic [3:0]        opcode;
    logic [RIDX_W-1:0] rd_idx, rs_idx;
    logic [DATA_W-1:0] rd_val, rs_val, imm_val, key_ext;
    logic [DATA_W:0]   sum_ext, diff_ext;
    logic [DATA_W-1:0] alu_res;
    logic              alu_upd;
    logic              key_rise;

    assign opcode  = ir_q[15:12];
    assign rd_idx  = ir_q[8 +: RIDX_W];
    assign rs_idx  = ir_q[RIDX_W-1:0];
    // Reads see the register file before this cycle's write, so rd==rs
    // operations naturally use the old value.
    assign rd_val  = rf_q[rd_idx];
    assign rs_val  = rf_q[rs_idx];
    assign imm_val = DATA_W'(ir_q[7:0]);
    assign key_ext = DATA_W'(key_value);
    // The extra top bit is carry-out for ADD and borrow for SUB.
    assign sum_ext  = {1'b0, rd_val} + {1'b0, rs_val};
    assign diff_ext = {1'b0, rd_val} - {1'b0, rs_val};
    // Only a 0->1 transition counts, so a key held from before INWAIT is ignored.
    assign key_rise = key_valid & ~key_prev_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        zero_flag_d  = zero_flag_q;
        sign_flag_d  = sign_flag_q;
        carry_flag_d = carry_flag_q;
        outreg_d     = outreg_q;
        out_valid_d  = 1'b0;
        kout_d       = kout_q;
        rf_we        = 1'b0;
        rf_waddr     = rd_idx;
        rf_wdata     = '0;
        alu_res      = '0;
        alu_upd      = 1'b0;
        case (state_q)
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_LDI: begin rf_we = 1'b1; rf_wdata = imm_val; end
                    OP_MOV: begin rf_we = 1'b1; rf_wdata = rs_val; end
                    OP_ADD: begin
                        alu_res      = sum_ext[DATA_W-1:0];
                        carry_flag_d = sum_ext[DATA_W];
                        alu_upd      = 1'b1;
                    end
                    OP_SUB: begin
                        alu_res      = diff_ext[DATA_W-1:0];
                        carry_flag_d = diff_ext[DATA_W];
                        alu_upd      = 1'b1;
                    end
                    OP_AND: begin alu_res = rd_val & rs_val; alu_upd = 1'b1; end
                    OP_OR:  begin alu_res = rd_val | rs_val; alu_upd = 1'b1; end
                    OP_IN:  state_d = S_INWAIT;
                    OP_OUT: begin outreg_d = rd_val; out_valid_d = 1'b1; end
                    OP_JMP: pc_d = ir_q[ADDR_W-1:0];
                    OP_JZ:  if (zero_flag_q) pc_d = ir_q[ADDR_W-1:0];
                    OP_JN:  if (sign_flag_q) pc_d = ir_q[ADDR_W-1:0];
                    OP_HALT: state_d = S_HALT;
                    default: ;
                endcase
                if (alu_upd) begin
                    rf_we       = 1'b1;
                    rf_wdata    = alu_res;
                    zero_flag_d = (alu_res == '0);
                    sign_flag_d = alu_res[DATA_W-1];
                end
            end
            S_INWAIT: begin
                if (key_rise) begin
                    rf_we    = 1'b1;
                    rf_wdata = key_ext;
                    kout_d   = key_value;
                    state_d  = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q      <= S_FETCH;
            pc_q         <= '0;
            ir_q         <= '0;
            zero_flag_q  <= 1'b0;
            sign_flag_q  <= 1'b0;
            carry_flag_q <= 1'b0;
            outreg_q     <= '0;
            out_valid_q  <= 1'b0;
            kout_q       <= '0;
            key_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            zero_flag_q  <= zero_flag_d;
            sign_flag_q  <= sign_flag_d;
            carry_flag_q <= carry_flag_d;
            outreg_q     <= outreg_d;
            out_valid_q  <= out_valid_d;
            kout_q       <= kout_d;
            key_prev_q   <= key_valid;
        end
    end

    // One flop bank per register; all cleared together on reset.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
        always_ff @(posedge clk) begin
            if (reset_p)
                rf_q[gi] <= '0;
            else if (rf_we && (rf_waddr == RIDX_W'(gi)))
                rf_q[gi] <= rf_wdata;
        end
    end

    assign imem_addr   = pc_q;
    assign imem_en     = (state_q == S_FETCH);
    assign halted      = (state_q == S_HALT);
    assign kout        = kout_q;
    assign outreg_data = outreg_q;
    assign out_valid   = out_valid_q;
endmodule
